// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 8;

   function automatic int cnt_w(input int width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// Combinational 1-bit full adder; the single arithmetic cell of the serial adder.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one fa_cell plus a carry flop, LSB-first, one bit per clock.
// Define SERIAL_ADDER_SUB_EN to add the 'sub' port (a - b via ~b and carry-in of 1).
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready for a start; last sum/cout held
// ST_RUN  | one bit per edge through fa_cell, WIDTH edges
// ST_DONE | single-cycle done pulse, result valid
module serial_adder_ctrl
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = cnt_w(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             fa_s;
   logic             fa_co;
   logic [WIDTH-1:0] b_load;
   logic             carry_load;

`ifdef SERIAL_ADDER_SUB_EN
   assign b_load     = sub ? ~b : b;
   assign carry_load = sub ? 1'b1 : cin;
`else
   assign b_load     = b;
   assign carry_load = cin;
`endif

   fa_cell u_fa (
      .a  (a_sh[0]),
      .b  (b_sh[0]),
      .ci (carry),
      .s  (fa_s),
      .co (fa_co)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start) state_nxt = ST_RUN;
         ST_RUN:  if (cnt == CNT_LAST) state_nxt = ST_DONE;
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign ready = (state == ST_IDLE);
   assign busy  = (state == ST_RUN) || (state == ST_DONE);
   assign done  = (state == ST_DONE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         a_sh  <= '0;
         b_sh  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  a_sh  <= a;
                  b_sh  <= b_load;
                  carry <= carry_load;
                  cnt   <= '0;
                  sum   <= '0;
                  cout  <= 1'b0;
               end
            end
            ST_RUN: begin
               // sum fills from the top so bit 0 lands in sum[0] after WIDTH shifts
               sum   <= {fa_s, sum[WIDTH-1:1]};
               a_sh  <= a_sh >> 1;
               b_sh  <= b_sh >> 1;
               carry <= fa_co;
               cnt   <= cnt + 1'b1;
               if (cnt == CNT_LAST) cout <= fa_co;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8) against an arithmetic reference model.
module tb_serial_adder_ctrl;

   localparam int W = 8;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         cin   = 1'b0;
   logic [W-1:0] a     = '0;
   logic [W-1:0] b     = '0;
`ifdef SERIAL_ADDER_SUB_EN
   logic         sub   = 1'b0;
`endif
   logic         ready;
   logic         busy;
   logic         done;
   logic         cout;
   logic [W-1:0] sum;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
      .sub   (sub),
`endif
      .ready (ready),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic c);
      int unsigned r;
      r = int'(x) + int'(y) + int'(c);
      return r[W:0];
   endfunction

   function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y);
      int unsigned r;
      r = int'(x) + (int'(1) << W) - int'(y);
      return r[W:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issues one operation from IDLE; lat is edges from accept to done (-1 if none within budget).
   task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc,
                        output int lat, output logic [W-1:0] osum, output logic ocout);
      a = oa; b = ob; cin = oc; start = 1'b1;
      tick();
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      lat = -1;
      for (int n = 1; n <= 20; n++) begin
         tick();
         if (done) begin
            lat = n;
            break;
         end
      end
      osum = sum; ocout = cout;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick(); tick();
      checks++;
      if ({ready, busy, done} !== 3'b100) begin
         errors++; $display("FAIL reset_flags: got %b expected 100", {ready, busy, done});
      end
      checks++;
      if ({cout, sum} !== '0) begin
         errors++; $display("FAIL reset_result: got %h expected 000", {cout, sum});
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (ready !== 1'b1) begin
         errors++; $display("FAIL reset_idle_hold: got ready=%b expected 1", ready);
      end
   endtask

   task automatic test_timing();
      a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      for (int n = 1; n <= 9; n++) begin
         tick();
         checks++;
         if (done !== (n == 8)) begin
            errors++; $display("FAIL timing_done n=%0d: got %b expected %b", n, done, n == 8);
         end
         checks++;
         if (ready !== (n == 9)) begin
            errors++; $display("FAIL timing_ready n=%0d: got %b expected %b", n, ready, n == 9);
         end
         if (n == 8) begin
            checks++;
            if ({cout, sum} !== 9'h010) begin
               errors++; $display("FAIL timing_result: got %h expected 010", {cout, sum});
            end
         end
      end
   endtask

   task automatic test_vectors();
      logic [W-1:0] va [3] = '{8'hFF, 8'hA5, 8'h00};
      logic [W-1:0] vb [3] = '{8'h01, 8'h5A, 8'h00};
      logic         vc [3] = '{1'b0, 1'b1, 1'b1};
      int lat;
      logic [W-1:0] s;
      logic co;
      for (int i = 0; i < 3; i++) begin
         do_op(va[i], vb[i], vc[i], lat, s, co);
         checks++;
         if (lat !== 8) begin
            errors++; $display("FAIL vec_latency %0d: got %0d expected 8", i, lat);
         end
         checks++;
         if ({co, s} !== ref_add(va[i], vb[i], vc[i])) begin
            errors++;
            $display("FAIL vec_result %0d: got %h expected %h", i, {co, s},
                     ref_add(va[i], vb[i], vc[i]));
         end
         tick();
      end
   endtask

   task automatic test_busy_ignore();
      logic [W:0] exp;
      exp = ref_add(8'h3C, 8'h42, 1'b0);
      a = 8'h3C; b = 8'h42; cin = 1'b0; start = 1'b1;
      tick();
      for (int n = 1; n <= 10; n++) begin
         start = 1'b0;
         if (n == 3) begin
            start = 1'b1; a = 8'h77; b = W'($urandom); cin = 1'b1;
         end else if (n == 9) begin
            start = 1'b1; a = 8'h11;
         end
         tick();
         if (n == 8) begin
            checks++;
            if (done !== 1'b1 || {cout, sum} !== exp) begin
               errors++;
               $display("FAIL busy_ignore_result: got done=%b %h expected done=1 %h",
                        done, {cout, sum}, exp);
            end
         end
         if (n == 9 || n == 10) begin
            checks++;
            if ({ready, busy, done} !== 3'b100) begin
               errors++;
               $display("FAIL busy_ignore_idle n=%0d: got %b expected 100", n, {ready, busy, done});
            end
            checks++;
            if ({cout, sum} !== exp) begin
               errors++; $display("FAIL busy_ignore_hold n=%0d: got %h expected %h", n, {cout, sum}, exp);
            end
         end
      end
      start = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      logic [W:0] exp;
      a = 8'hC3; b = 8'h7E; cin = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      rst_n = 1'b0;
      tick();
      checks++;
      if ({ready, busy, done} !== 3'b100) begin
         errors++; $display("FAIL midrun_reset_flags: got %b expected 100", {ready, busy, done});
      end
      checks++;
      if ({cout, sum} !== '0) begin
         errors++; $display("FAIL midrun_reset_result: got %h expected 000", {cout, sum});
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (done !== 1'b0 || ready !== 1'b1) begin
         errors++; $display("FAIL midrun_after: got done=%b ready=%b expected 0 1", done, ready);
      end
      exp = ref_add(8'h29, 8'hE4, 1'b0);
      a = 8'h29; b = 8'hE4; cin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      for (int n = 1; n <= 8; n++) begin
         tick();
         checks++;
         if (done !== (n == 8)) begin
            errors++; $display("FAIL midrun_restart_done n=%0d: got %b expected %b", n, done, n == 8);
         end
      end
      checks++;
      if ({cout, sum} !== exp) begin
         errors++; $display("FAIL midrun_restart_result: got %h expected %h", {cout, sum}, exp);
      end
      tick();
   endtask

   task automatic test_random();
      int lat;
      int gap;
      int bad = 0;
      logic [W-1:0] ra, rb, s;
      logic rc, co;
      for (int i = 0; i < 1000; i++) begin
         ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
         do_op(ra, rb, rc, lat, s, co);
         checks++;
         if (lat !== 8 || {co, s} !== ref_add(ra, rb, rc)) begin
            errors++;
            if (bad++ < 10)
               $display("FAIL random_op %0d: got lat=%0d %h expected lat=8 %h",
                        i, lat, {co, s}, ref_add(ra, rb, rc));
         end
         tick();
         checks++;
         if (done !== 1'b0 || ready !== 1'b1) begin
            errors++;
            if (bad++ < 10)
               $display("FAIL random_single_done %0d: got done=%b ready=%b expected 0 1", i, done, ready);
         end
         gap = int'($urandom_range(0, 3));
         for (int g = 0; g < gap; g++) tick();
      end
   endtask

`ifdef SERIAL_ADDER_SUB_EN
   task automatic test_sub();
      logic [W-1:0] va [4] = '{8'h10, 8'h01, 8'h80, 8'h5A};
      logic [W-1:0] vb [4] = '{8'h01, 8'h02, 8'h80, 8'hC3};
      int lat;
      logic [W-1:0] s;
      logic co;
      sub = 1'b1;
      for (int i = 0; i < 4; i++) begin
         do_op(va[i], vb[i], 1'($urandom), lat, s, co);
         checks++;
         if (lat !== 8 || {co, s} !== ref_sub(va[i], vb[i])) begin
            errors++;
            $display("FAIL sub_result %0d: got lat=%0d %h expected lat=8 %h",
                     i, lat, {co, s}, ref_sub(va[i], vb[i]));
         end
         tick();
      end
      sub = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_timing();
      test_vectors();
      test_busy_ignore();
      test_reset_mid_run();
      test_random();
`ifdef SERIAL_ADDER_SUB_EN
      test_sub();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
